// File: rtl/gf2_mul_scheduler.sv
`default_nettype none
// ============================================================================
// gf2_mul_scheduler: round-robin front end sharing one GF(2) multiplier core
// Revision: 1.0
// ============================================================================
module gf2_mul_scheduler #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int OP_W       = 17669,
    parameter int RES_W      = 35338,
    parameter int RST_CYCLES = 1,
    parameter int MAX_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*OP_W-1:0]   req_u,
    input  logic [N_REQ*OP_W-1:0]   req_v,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_w,
    output logic                    rsp_err,
    output logic [31:0]             cycles,
    output logic                    busy,
    output logic                    core_rst,
    output logic [OP_W-1:0]         core_u,
    output logic [OP_W-1:0]         core_v,
    input  logic [RES_W-1:0]        core_w,
    input  logic                    core_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_grant_idx;
    logic [ID_W-1:0] w_ptr_next;
    logic [ID_W:0]   w_cand;
    logic            w_grant_any;
    logic            w_take;
    logic [OP_W-1:0] w_sel_u;
    logic [OP_W-1:0] w_sel_v;
    logic [31:0]     r_load_cnt;
    logic [31:0]     r_run_cnt;
    logic            w_load_last;
    logic            w_run_tmo;

    // First valid requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(N_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(N_REQ);
            end
            if (!w_grant_any && req_valid[w_cand[ID_W-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_u = '0;
        w_sel_v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_u = req_u[i*OP_W +: OP_W];
                w_sel_v = req_v[i*OP_W +: OP_W];
            end
        end
    end

    assign w_take      = reset && (r_state == S_IDLE) && w_grant_any;
    assign req_ready   = w_take ? (N_REQ'(1) << w_grant_idx) : '0;
    assign w_ptr_next  = (w_grant_idx == ID_W'(N_REQ-1)) ? '0 : w_grant_idx + 1'b1;
    assign w_load_last = (r_load_cnt == 32'(RST_CYCLES));
    assign w_run_tmo   = (r_run_cnt == 32'(MAX_CYCLES));

    assign busy      = (r_state != S_IDLE);
    assign core_rst  = (r_state != S_RUN);
    assign rsp_valid = (r_state == S_RESP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_next = S_LOAD;
            S_LOAD:  if (w_load_last) w_state_next = S_RUN;
            S_RUN:   if (core_done || w_run_tmo) w_state_next = S_RESP;
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_load_cnt <= '0;
            r_run_cnt  <= '0;
            core_u     <= '0;
            core_v     <= '0;
            rsp_id     <= '0;
            rsp_w      <= '0;
            rsp_err    <= 1'b0;
            cycles     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        core_u     <= w_sel_u;
                        core_v     <= w_sel_v;
                        rsp_id     <= w_grant_idx;
                        r_ptr      <= w_ptr_next;
                        r_load_cnt <= 32'd1;
                    end
                end
                S_LOAD: begin
                    r_load_cnt <= r_load_cnt + 32'd1;
                    r_run_cnt  <= 32'd1;
                end
                S_RUN: begin
                    // Completion takes priority over the watchdog in the same cycle.
                    if (core_done) begin
                        rsp_w   <= core_w;
                        rsp_err <= 1'b0;
                        cycles  <= r_run_cnt;
                    end else if (w_run_tmo) begin
                        rsp_w   <= '0;
                        rsp_err <= 1'b1;
                        cycles  <= 32'(MAX_CYCLES);
                    end else begin
                        r_run_cnt <= r_run_cnt + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf2_mul_scheduler.sv
`default_nettype none
// ============================================================================
// tb_gf2_mul_scheduler: directed + randomized bench with a GF(2) core model
// Revision: 1.0
// ============================================================================
module tb_gf2_mul_scheduler;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int OPW  = 80;
    localparam int RESW = 160;
    localparam int RSTC = 2;
    localparam int MAXC = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*OPW-1:0]  req_u;
    logic [N*OPW-1:0]  req_v;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [RESW-1:0]   rsp_w;
    logic              rsp_err;
    logic [31:0]       cycles;
    logic              busy;
    logic              core_rst;
    logic [OPW-1:0]    core_u;
    logic [OPW-1:0]    core_v;
    logic [RESW-1:0]   core_w;
    logic              core_done;

    logic [OPW-1:0]    u_arr [N];
    logic [OPW-1:0]    v_arr [N];
    int                run_k = 0;
    int                done_at = 0;
    bit                force_done = 1'b0;
    int                tests = 0;
    int                fails = 0;
    int                mptr = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_u[gi*OPW +: OPW] = u_arr[gi];
        assign req_v[gi*OPW +: OPW] = v_arr[gi];
    end

    gf2_mul_scheduler #(
        .N_REQ(N), .ID_W(IDW), .OP_W(OPW), .RES_W(RESW),
        .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_u(req_u), .req_v(req_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_w(rsp_w), .rsp_err(rsp_err),
        .cycles(cycles), .busy(busy), .core_rst(core_rst),
        .core_u(core_u), .core_v(core_v),
        .core_w(core_w), .core_done(core_done)
    );

    function automatic logic [RESW-1:0] gf2mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic [RESW-1:0] r;
        r = '0;
        for (int i = 0; i < OPW; i++) begin
            if (a[i]) r = r ^ (RESW'(b) << i);
        end
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Core model: counts cycles out of reset and raises done in RUN cycle done_at.
    always @(posedge clk) begin
        if (core_rst) run_k <= 0;
        else          run_k <= run_k + 1;
    end
    assign core_done = force_done | (!core_rst && done_at != 0 && run_k + 1 == done_at);
    assign core_w    = gf2mul(core_u, core_v);

    task automatic chk(input string tag, input logic [RESW-1:0] obs, input logic [RESW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input int dat, input int bp, input bit spur);
        int id, c, k, exp_lat;
        bit got;
        logic [RESW-1:0] exp_w;
        logic [OPW-1:0] eu, ev;
        id = pick(req_valid, mptr);
        if (id < 0) return;
        done_at    = dat;
        force_done = spur;
        #1;
        chk("grant", RESW'(req_ready), RESW'(N'(1) << id));
        chk("busy_idle", RESW'(busy), RESW'(0));
        eu      = u_arr[id];
        ev      = v_arr[id];
        k       = (dat == 0) ? MAXC : dat;
        exp_lat = RSTC + 1 + k;
        exp_w   = (dat == 0) ? '0 : gf2mul(eu, ev);
        mptr    = (id + 1) % N;
        got = 1'b0;
        c   = 0;
        while (!got && c < exp_lat + 5) begin
            @(negedge clk);
            c++;
            if (c == 1) req_valid[id] = 1'b0;
            if (c == RSTC + 1) force_done = 1'b0;
            if (rsp_valid === 1'b1) got = 1'b1;
            else chk("core_rst", RESW'(core_rst), RESW'(c <= RSTC));
        end
        chk("rsp_seen", RESW'(got), RESW'(1));
        chk("latency", RESW'(c), RESW'(exp_lat));
        chk("rsp_id", RESW'(rsp_id), RESW'(id));
        chk("rsp_w", rsp_w, exp_w);
        chk("rsp_err", RESW'(rsp_err), RESW'(dat == 0));
        chk("cycles", RESW'(cycles), RESW'(k));
        chk("core_u", RESW'(core_u), RESW'(eu));
        chk("core_v", RESW'(core_v), RESW'(ev));
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            chk("bp_valid", RESW'(rsp_valid), RESW'(1));
            chk("bp_w", rsp_w, exp_w);
            chk("bp_id", RESW'(rsp_id), RESW'(id));
            chk("bp_ready", RESW'(req_ready), RESW'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_busy", RESW'(busy), RESW'(0));
        chk("idle_valid", RESW'(rsp_valid), RESW'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            u_arr[i] = {$urandom, $urandom, $urandom};
            v_arr[i] = {$urandom, $urandom, $urandom};
        end
        // Reset with every requester already asserting.
        reset     = 1'b0;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", RESW'(req_ready), RESW'(0));
        chk("rst_rsp_valid", RESW'(rsp_valid), RESW'(0));
        chk("rst_rsp_id", RESW'(rsp_id), RESW'(0));
        chk("rst_rsp_w", rsp_w, RESW'(0));
        chk("rst_rsp_err", RESW'(rsp_err), RESW'(0));
        chk("rst_cycles", RESW'(cycles), RESW'(0));
        chk("rst_busy", RESW'(busy), RESW'(0));
        chk("rst_core_rst", RESW'(core_rst), RESW'(1));
        chk("rst_core_u", RESW'(core_u), RESW'(0));
        chk("rst_core_v", RESW'(core_v), RESW'(0));
        reset = 1'b1;

        // Contention: 0,1,2,3 then 0 (wrapped) and 3.
        for (int i = 0; i < N; i++) serve(3 + i, 0, 1'b0);
        req_valid = 4'b1001;
        serve(1, 0, 1'b0);
        serve(7, 0, 1'b0);

        // Single request from requester 2 with fixed operands.
        u_arr[2]  = 80'd48923784923877589134;
        v_arr[2]  = 80'd23984576993284592348;
        req_valid = 4'b0100;
        serve(10, 0, 1'b0);

        // Backpressure with requester 1 waiting behind requester 0.
        req_valid = 4'b0011;
        serve(4, 5, 1'b0);
        serve(2, 0, 1'b0);

        // Watchdog expiry, then done exactly at the limit.
        req_valid[3] = 1'b1;
        serve(0, 0, 1'b0);
        req_valid[1] = 1'b1;
        serve(MAXC, 0, 1'b0);

        // Spurious done during IDLE and LOAD.
        req_valid[0] = 1'b1;
        serve(5, 0, 1'b1);

        // Reset mid-RUN on requester 1's operation.
        req_valid = 4'b0010;
        done_at   = 0;
        #1;
        chk("abort_grant", RESW'(req_ready), RESW'(4'b0010));
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (RSTC + 2) @(negedge clk);
        chk("abort_in_run", RESW'(core_rst), RESW'(0));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", RESW'(busy), RESW'(0));
        chk("abort_core_rst", RESW'(core_rst), RESW'(1));
        chk("abort_rsp_valid", RESW'(rsp_valid), RESW'(0));
        chk("abort_cycles", RESW'(cycles), RESW'(0));
        mptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", RESW'(rsp_valid), RESW'(0));
        end
        req_valid = 4'b0110;
        serve(6, 1, 1'b0);

        // Randomized traffic; operands only change for idle requesters.
        for (int it = 0; it < 12; it++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int j = 0; j < N; j++) begin
                if (m[j] && !req_valid[j]) begin
                    u_arr[j]     = {$urandom, $urandom, $urandom};
                    v_arr[j]     = {$urandom, $urandom, $urandom};
                    req_valid[j] = 1'b1;
                end
            end
            serve(int'($urandom_range(0, MAXC)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
